mem: RTL and testbench



---
 rtl/mem_pkg.sv | 11 +
 rtl/mem_array.sv | 34 +++
 rtl/mem.sv | 65 ++++++
 tb/tb_mem.sv | 131 +++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - default geometry and word/address types for the mem scratchpad RAM
package mem_pkg;

    localparam int MEM_DATA_W = 8;
    localparam int MEM_ADDR_W = 4;
    localparam int MEM_DEPTH  = 16;

    typedef logic [MEM_ADDR_W-1:0] mem_addr_t;
    typedef logic [MEM_DATA_W-1:0] mem_data_t;

endpackage : mem_pkg

// File: rtl/mem_array.sv
// rtl/mem_array.sv - storage array with asynchronous clear, one write port and a combinational read tap
import mem_pkg::*;

module mem_array #(
    parameter int DATA_W = MEM_DATA_W,
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DEPTH  = MEM_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Every word clears the moment reset asserts; otherwise write the addressed word on we.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read tap returns the pre-edge contents; the caller registers it.
    assign rdata = mem_q[raddr];

endmodule : mem_array

// File: rtl/mem.sv
// rtl/mem.sv - 16x8 single-port RAM with registered read; MEM_BYPASS_EN enables write-through on wr&rd
import mem_pkg::*;

module mem #(
    parameter int DATA_W = MEM_DATA_W,
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DEPTH  = MEM_DEPTH
) (
    input  logic              Clk,
    input  logic              rst,
    input  logic              wr,
    input  logic              rd,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] Data_in,
    output logic [DATA_W-1:0] Data_out
);

    logic [DATA_W-1:0] array_rdata;
    logic              do_write;
    logic              do_read;
    logic              do_bypass;
    logic              out_load;
    logic [DATA_W-1:0] out_next;

    mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (Clk),
        .rst_n (rst),
        .we    (do_write),
        .waddr (addr),
        .wdata (Data_in),
        .raddr (addr),
        .rdata (array_rdata)
    );

    // Strobe priority: a write always happens; a plain read only when no write shares the edge.
    always_comb begin
        do_write  = wr;
        do_read   = rd && !wr;
`ifdef MEM_BYPASS_EN
        do_bypass = rd && wr;
`else
        do_bypass = 1'b0;
`endif
    end

    // Select what (if anything) loads into the output register this edge.
    always_comb begin
        out_load = do_read || do_bypass;
        out_next = do_bypass ? Data_in : array_rdata;
    end

    // Output register: clears with the array, otherwise changes only on a read.
    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            Data_out <= '0;
        end else if (out_load) begin
            Data_out <= out_next;
        end
    end

endmodule : mem

// File: tb/tb_mem.sv
// tb/tb_mem.sv - directed self-checking bench for mem (expectations follow MEM_BYPASS_EN)
import mem_pkg::*;

module tb_mem;

    logic      Clk;
    logic      rst;
    logic      wr;
    logic      rd;
    mem_addr_t addr;
    mem_data_t Data_in;
    mem_data_t Data_out;

    int n_checks = 0;
    int n_fail   = 0;

    mem dut (
        .Clk      (Clk),
        .rst      (rst),
        .wr       (wr),
        .rd       (rd),
        .addr     (addr),
        .Data_in  (Data_in),
        .Data_out (Data_out)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input mem_data_t obs, input mem_data_t exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    // Apply one operation between edges, return 1 time unit after the sampling edge.
    task automatic op(input logic w, input logic r, input mem_addr_t a, input mem_data_t d);
        @(negedge Clk);
        wr      = w;
        rd      = r;
        addr    = a;
        Data_in = d;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        mem_data_t exp_both;
        wr = 0; rd = 0; addr = '0; Data_in = '0;
        rst = 1'b0;
        #1;
        check("reset_dout_immediate", Data_out, 8'h00);
        @(posedge Clk);
        @(negedge Clk);
        rst = 1'b1;

        // Fresh memory reads zero everywhere
        for (int i = 0; i < 16; i++) begin
            op(0, 1, mem_addr_t'(i), 8'h5A);
            check($sformatf("reset_read_%0d", i), Data_out, 8'h00);
        end

        op(1, 0, 4'd0, 8'hAA);
        check("write_only_holds_dout", Data_out, 8'h00);
        op(0, 1, 4'd0, 8'h00);
        check("read_addr0", Data_out, 8'hAA);
        op(1, 0, 4'd1, 8'hBB);
        op(0, 1, 4'd1, 8'h00);
        check("read_addr1", Data_out, 8'hBB);
        op(0, 1, 4'd0, 8'h00);
        check("reread_addr0", Data_out, 8'hAA);
        op(0, 0, 4'd3, 8'h77);
        check("idle_holds_dout", Data_out, 8'hAA);
        op(0, 1, 4'd1, 8'h00);
        check("read_addr1_again", Data_out, 8'hBB);

        // Simultaneous strobes
`ifdef MEM_BYPASS_EN
        exp_both = 8'hCC;
`else
        exp_both = 8'hBB;
`endif
        op(1, 1, 4'd2, 8'hCC);
        check("both_strobes_dout", Data_out, exp_both);
        op(0, 1, 4'd2, 8'h00);
        check("read_after_both", Data_out, 8'hCC);

        // Back-to-back writes then reads
        for (int i = 0; i < 16; i++) begin
            op(1, 0, mem_addr_t'(i), mem_data_t'(8'h10 + i));
        end
        for (int i = 0; i < 16; i++) begin
            op(0, 1, mem_addr_t'(i), 8'h00);
            check($sformatf("b2b_read_%0d", i), Data_out, mem_data_t'(8'h10 + i));
        end

        // Asynchronous reset mid-cycle, with a write pending that must be ignored
        #2;
        wr = 1; rd = 1; addr = 4'd5; Data_in = 8'hFF;
        rst = 1'b0;
        #1;
        check("async_reset_dout", Data_out, 8'h00);
        @(posedge Clk);
        #1;
        check("reset_ignores_strobes", Data_out, 8'h00);
        @(negedge Clk);
        wr = 0; rd = 0;
        rst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            op(0, 1, mem_addr_t'(i), 8'h00);
            check($sformatf("post_reset_read_%0d", i), Data_out, 8'h00);
        end

        // First edges after reset operate normally
        op(1, 0, 4'd15, 8'h3C);
        op(0, 1, 4'd15, 8'h00);
        check("post_reset_write_read", Data_out, 8'h3C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_mem
